// File: rtl/quadrature_gen.sv
// quadrature_gen: quadrature A/B waveform generator (transmit side of the
// rotary-encoder interface). It accepts a target position through a
// valid/ready command port. It then steps Gray-coded A/B phases at a
// programmable rate until the internal position reaches the target.
//
// Optional build macro: QUAD_GEN_RETARGET_EN
//   When defined, commands are also accepted while a move is running. The new
//   target and ticks take effect immediately. The direction is only re-chosen
//   at the next count boundary (a/b == 00), so a cycle in flight always
//   completes first.
module quadrature_gen #(
  parameter int POS_W  = 8,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [POS_W-1:0]  cmd_target,
  input  logic [TICK_W-1:0] phase_ticks,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  // Latched move parameters
  logic [POS_W-1:0]  target;
  logic [TICK_W-1:0] ticks;

  // Rate divider and phase tracking
  logic [TICK_W-1:0] counter;
  logic [1:0]        phase;   // 0..3 within one count; 0 means a/b == 00
  logic              down;    // direction of the count currently in flight

  // Combinational helpers
  logic              cmd_fire;
  logic              retarget_fire;
  logic [TICK_W-1:0] cmd_ticks;
  logic [POS_W-1:0]  diff;
  logic              step_down;
  logic [1:0]        phase_next;
  logic [1:0]        ab_next;
  logic              count_done;
  logic [POS_W-1:0]  pos_step;
  logic [POS_W-1:0]  pos_next;
  logic              reached;
  logic              run_ready;

  // Command handshake and step decode
  always_comb begin
    cmd_fire   = cmd_valid & cmd_ready;
    cmd_ticks  = (phase_ticks == '0) ? TICK_W'(1) : phase_ticks;
    diff       = target - position;
    // Direction is chosen only when leaving a/b == 00; mid-cycle we keep going
    step_down  = (phase == 2'd0) ? diff[POS_W-1] : down;
    phase_next = phase + 2'd1;
    count_done = (phase == 2'd3);
    pos_step   = step_down ? (position - POS_W'(1)) : (position + POS_W'(1));
    pos_next   = count_done ? pos_step : position;
    reached    = count_done && (pos_step == target);
    ab_next    = 2'b00;
    case (phase_next)
      2'd0: ab_next = 2'b00;
      2'd1: ab_next = step_down ? 2'b01 : 2'b10;
      2'd2: ab_next = 2'b11;
      2'd3: ab_next = step_down ? 2'b10 : 2'b01;
      default: ab_next = 2'b00;
    endcase
`ifdef QUAD_GEN_RETARGET_EN
    run_ready     = 1'b1;
    retarget_fire = cmd_fire && (state == RUN);
`else
    run_ready     = 1'b0;
    retarget_fire = 1'b0;
`endif
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      ticks     <= '0;
      counter   <= '0;
      phase     <= 2'd0;
      down      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_target == position) begin
              // Null move: report completion without touching a/b
              done <= 1'b1;
            end else begin
              target    <= cmd_target;
              ticks     <= cmd_ticks;
              counter   <= cmd_ticks;
              state     <= RUN;
              busy      <= 1'b1;
              cmd_ready <= run_ready;
            end
          end
        end

        RUN: begin
          if (counter == TICK_W'(1)) begin
            counter <= ticks;
            if ((phase == 2'd0) && (diff == '0)) begin
              // A retarget landed on the current position at a boundary
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              counter   <= '0;
            end else begin
              phase    <= phase_next;
              a        <= ab_next[1];
              b        <= ab_next[0];
              down     <= step_down;
              position <= pos_next;
              // Completion only on a full cycle; a fresh retarget defers it
              if (reached && !retarget_fire) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                counter   <= '0;
              end
            end
          end else begin
            counter <= counter - TICK_W'(1);
          end
          if (retarget_fire) begin
            target <= cmd_target;
            ticks  <= cmd_ticks;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_gen.sv
// Self-checking bench for quadrature_gen. Each move is modelled up front: the
// expected a/b/position/done events are pushed to a scoreboard queue, and a
// negedge monitor pops and compares every observed change.
module tb_quadrature_gen;

  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_target = 8'd0;
  logic [15:0] phase_ticks = 16'd0;
  logic        a, b, busy, done;
  logic [7:0]  position;

  quadrature_gen #(.POS_W(8), .TICK_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .phase_ticks(phase_ticks), .a(a), .b(b),
    .busy(busy), .done(done), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] ab;
    logic [7:0] pos;
    logic       dn;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [1:0] prev_ab = 2'b00;
  logic [7:0] prev_pos = 8'd0;

`ifdef QUAD_GEN_RETARGET_EN
  localparam logic RUN_READY = 1'b1;
`else
  localparam logic RUN_READY = 1'b0;
`endif

  // Scoreboard monitor: any change of a/b/position, or a done pulse, is one event
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_ab  = {a, b};
      prev_pos = position;
    end else if ({a, b} !== prev_ab || position !== prev_pos || done !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d ab=%b pos=%0d done=%b", cyc, {a, b}, position, done);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.ab !== {a, b} || e.pos !== position || e.dn !== done) begin
          errors++;
          $display("FAIL event got cyc=%0d ab=%b pos=%0d done=%b want cyc=%0d ab=%b pos=%0d done=%b",
                   cyc, {a, b}, position, done, e.cyc, e.ab, e.pos, e.dn);
        end else begin
          $display("event cyc=%0d ab=%b pos=%0d done=%b", cyc, {a, b}, position, done);
        end
      end
      prev_ab  = {a, b};
      prev_pos = position;
    end
  end

  function automatic logic [1:0] ab_of(input int ph, input bit dn);
    case (ph)
      1: return dn ? 2'b01 : 2'b10;
      2: return 2'b11;
      3: return dn ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model of one move; rt_cycle/rt_tgt model a retarget landing at that edge
  task automatic plan(input logic [7:0] start, input logic [7:0] tgt, input int ticks,
                      input int e0, input int limit, input int rt_cycle, input logic [7:0] rt_tgt);
    int t;
    int ph;
    int k;
    int c;
    bit dn;
    bit fin;
    logic [7:0] pos;
    logic [7:0] cur;
    logic [7:0] d;
    t = (ticks == 0) ? 1 : ticks;
    pos = start;
    ph = 0;
    dn = 1'b0;
    k = 0;
    if (tgt == start) begin
      exp_q.push_back('{e0, 2'b00, start, 1'b1});
      return;
    end
    while (k < 5000) begin
      k++;
      c = e0 + k * t;
      if (c >= limit) break;
      cur = (c > rt_cycle) ? rt_tgt : tgt;
      if (ph == 0) begin
        d = cur - pos;
        if (d == 8'd0) begin
          exp_q.push_back('{c, 2'b00, pos, 1'b1});
          break;
        end
        dn = d[7];
      end
      ph = (ph + 1) % 4;
      if (ph == 0) pos = dn ? pos - 8'd1 : pos + 8'd1;
      fin = (ph == 0) && (pos == cur);
      exp_q.push_back('{c, ab_of(ph, dn), pos, fin});
      if (fin) break;
    end
  endtask

  task automatic send(input logic [7:0] tgt, input logic [15:0] tk, output int e0);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_target  = tgt;
    phase_ticks = tk;
    @(posedge clk);
    #1;
    e0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_idle busy/ready=%b want 01", name, {busy, cmd_ready});
    end else begin
      $display("%s idle busy=0 ready=1 pos=%0d", name, position);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a, b, busy, done, cmd_ready, position} !== {5'b00001, 8'd0}) begin
      errors++;
      $display("FAIL reset_held got %b want %b", {a, b, busy, done, cmd_ready, position}, {5'b00001, 8'd0});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a, b, busy, done, cmd_ready, position} !== {5'b00001, 8'd0}) begin
      errors++;
      $display("FAIL reset_release got %b want %b", {a, b, busy, done, cmd_ready, position}, {5'b00001, 8'd0});
    end else begin
      $display("reset a=b=0 pos=0 busy=0 done=0 ready=1");
    end
    mon_en = 1'b1;
  endtask

  task automatic test_up();
    int e0;
    send(8'd3, 16'd2, e0);
    plan(8'd0, 8'd3, 2, e0, BIG, BIG, 8'd0);
    checks++;
    if ({busy, cmd_ready} !== {1'b1, RUN_READY}) begin
      errors++;
      $display("FAIL up_busy busy/ready=%b want %b", {busy, cmd_ready}, {1'b1, RUN_READY});
    end
    drain("up");
  endtask

  task automatic test_wrap();
    int e0;
    do_reset();
    send(8'd254, 16'd1, e0);
    plan(8'd0, 8'd254, 1, e0, BIG, BIG, 8'd0);
    drain("wrap");
  endtask

  task automatic test_null();
    int e0;
    send(8'd254, 16'd5, e0);
    plan(8'd254, 8'd254, 5, e0, BIG, BIG, 8'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL null_busy busy=%b want 0", busy);
    end
    drain("null");
    // Zero ticks runs at one phase per cycle
    send(8'd255, 16'd0, e0);
    plan(8'd254, 8'd255, 0, e0, BIG, BIG, 8'd0);
    drain("ticks0");
  endtask

  task automatic test_reset_mid();
    int e0;
    do_reset();
    send(8'd10, 16'd4, e0);
    plan(8'd0, 8'd10, 4, e0, e0 + 13, BIG, 8'd0);
    exp_q.push_back('{e0 + 13, 2'b00, 8'd0, 1'b0});
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({a, b, busy, done, cmd_ready, position} !== {5'b00001, 8'd0}) begin
      errors++;
      $display("FAIL midreset got %b want %b", {a, b, busy, done, cmd_ready, position}, {5'b00001, 8'd0});
    end
    drain("midreset");
  endtask

  task automatic test_retarget();
    int e0;
    int e0b;
    int n;
    do_reset();
    send(8'd5, 16'd1, e0);
`ifdef QUAD_GEN_RETARGET_EN
    plan(8'd0, 8'd5, 1, e0, BIG, e0 + 10, 8'd0);
`else
    plan(8'd0, 8'd5, 1, e0, BIG, BIG, 8'd0);
`endif
    repeat (9) @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_target  = 8'd0;
    phase_ticks = 16'd1;
    checks++;
    if (cmd_ready !== RUN_READY) begin
      errors++;
      $display("FAIL retarget_ready ready=%b want %b", cmd_ready, RUN_READY);
    end
`ifdef QUAD_GEN_RETARGET_EN
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
`else
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || position !== 8'd5) begin
      errors++;
      $display("FAIL held_cmd ready=%b pos=%0d want ready=1 pos=5", cmd_ready, position);
    end
    @(posedge clk);
    #1;
    e0b = cyc;
    cmd_valid = 1'b0;
    plan(8'd5, 8'd0, 1, e0b, BIG, BIG, 8'd0);
`endif
    drain("retarget");
  endtask

  initial begin
    test_reset();
    test_up();
    test_wrap();
    test_null();
    test_reset_mid();
    test_retarget();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
